// File: rtl/pong_game_ctrl.sv
// Pong frame sequencer: derives one update tick per VGA frame and advances
// paddles, ball, collisions, scores and the serve/play/game-over state machine.
module pong_game_ctrl #(
    parameter int HD           = 640,
    parameter int VD           = 480,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 72,
    parameter int PAD_VEL      = 3,
    parameter int LPAD_X       = 32,
    parameter int RPAD_X       = 600,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_VEL     = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       start,
    output logic [9:0] lpad_y,
    output logic [9:0] rpad_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] game_state,
    output logic       game_over,
    output logic       frame_tick
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] P_VEL   = 10'(PAD_VEL);
    localparam logic [9:0] P_MAX   = 10'(VD - PAD_H);
    localparam logic [9:0] P_INIT  = 10'((VD - PAD_H) / 2);
    localparam logic [9:0] VD_CNT  = 10'(VD);

    localparam logic signed [10:0] C_BV   = 11'(BALL_VEL);
    localparam logic signed [10:0] C_BS   = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_VD   = 11'(VD);
    localparam logic signed [10:0] C_HD   = 11'(HD);
    localparam logic signed [10:0] C_PH   = 11'(PAD_H);
    localparam logic signed [10:0] C_LX   = 11'(LPAD_X);
    localparam logic signed [10:0] C_LHIT = 11'(LPAD_X + PAD_W);
    localparam logic signed [10:0] C_RX   = 11'(RPAD_X);
    localparam logic signed [10:0] C_RRIM = 11'(RPAD_X + PAD_W);
    localparam logic signed [10:0] C_CX   = 11'((HD - BALL_SIZE) / 2);
    localparam logic signed [10:0] C_CY   = 11'((VD - BALL_SIZE) / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [9:0]         lpad_reg, lpad_next, rpad_reg, rpad_next;
    logic signed [10:0] bx_reg, bx_next, by_reg, by_next;
    logic [3:0]         score_l_reg, score_l_next, score_r_reg, score_r_next;
    logic               dx_neg_reg, dx_neg_next, dy_neg_reg, dy_neg_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               cond_q_reg, tick_reg, over_reg;
    logic               cond;

    // Clamped paddle step; both or neither button holds position.
    function automatic logic [9:0] pad_step(input logic [9:0] p, input logic up, input logic dn);
        if (up && !dn)
            return (p < P_VEL) ? 10'd0 : p - P_VEL;
        else if (dn && !up)
            return (p > P_MAX - P_VEL) ? P_MAX : p + P_VEL;
        else
            return p;
    endfunction

    assign cond = (x == 10'd0) && (y == VD_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            lpad_reg    <= P_INIT;
            rpad_reg    <= P_INIT;
            bx_reg      <= C_CX;
            by_reg      <= C_CY;
            score_l_reg <= 4'd0;
            score_r_reg <= 4'd0;
            dx_neg_reg  <= 1'b0;
            dy_neg_reg  <= 1'b0;
            cnt_reg     <= '0;
            cond_q_reg  <= 1'b0;
            tick_reg    <= 1'b0;
            over_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lpad_reg    <= lpad_next;
            rpad_reg    <= rpad_next;
            bx_reg      <= bx_next;
            by_reg      <= by_next;
            score_l_reg <= score_l_next;
            score_r_reg <= score_r_next;
            dx_neg_reg  <= dx_neg_next;
            dy_neg_reg  <= dy_neg_next;
            cnt_reg     <= cnt_next;
            cond_q_reg  <= cond;
            tick_reg    <= cond & ~cond_q_reg;
            over_reg    <= (state_next == S_OVER);
        end
    end

    logic signed [10:0] lpad_s, rpad_s, vy, vx;
    logic               vdy_neg, l_ovl, r_ovl;
    logic [CW-1:0]      cnt_inc;
    logic [3:0]         sl_inc, sr_inc;

    always_comb begin
        state_next   = state_reg;
        lpad_next    = lpad_reg;
        rpad_next    = rpad_reg;
        bx_next      = bx_reg;
        by_next      = by_reg;
        score_l_next = score_l_reg;
        score_r_next = score_r_reg;
        dx_neg_next  = dx_neg_reg;
        dy_neg_next  = dy_neg_reg;
        cnt_next     = cnt_reg;
        lpad_s       = signed'({1'b0, lpad_reg});
        rpad_s       = signed'({1'b0, rpad_reg});
        cnt_inc      = cnt_reg + CW'(1);
        sl_inc       = score_l_reg + 4'd1;
        sr_inc       = score_r_reg + 4'd1;
        l_ovl        = (by_reg + C_BS > lpad_s) && (by_reg < lpad_s + C_PH);
        r_ovl        = (by_reg + C_BS > rpad_s) && (by_reg < rpad_s + C_PH);

        // Vertical axis resolves independently of the horizontal one.
        vdy_neg = dy_neg_reg;
        if (dy_neg_reg && by_reg < C_BV) begin
            vy      = 11'sd0;
            vdy_neg = 1'b0;
        end else if (!dy_neg_reg && by_reg + C_BS + C_BV > C_VD) begin
            vy      = C_VD - C_BS;
            vdy_neg = 1'b1;
        end else begin
            vy = dy_neg_reg ? by_reg - C_BV : by_reg + C_BV;
        end
        vx = dx_neg_reg ? bx_reg - C_BV : bx_reg + C_BV;

        case (state_reg)
            S_IDLE: begin
                bx_next = C_CX;
                by_next = C_CY;
                if (start) begin
                    state_next   = S_SERVE;
                    score_l_next = 4'd0;
                    score_r_next = 4'd0;
                    cnt_next     = '0;
                end
            end
            S_SERVE: begin
                bx_next = C_CX;
                by_next = C_CY;
                if (tick_reg) begin
                    lpad_next = pad_step(lpad_reg, btn_l_up, btn_l_dn);
                    rpad_next = pad_step(rpad_reg, btn_r_up, btn_r_dn);
                    if (cnt_inc == CW'(SERVE_FRAMES)) begin
                        state_next = S_PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            S_PLAY: begin
                if (tick_reg) begin
                    lpad_next   = pad_step(lpad_reg, btn_l_up, btn_l_dn);
                    rpad_next   = pad_step(rpad_reg, btn_r_up, btn_r_dn);
                    by_next     = vy;
                    dy_neg_next = vdy_neg;
                    bx_next     = vx;
                    if (dx_neg_reg && bx_reg - C_BV <= C_LHIT && bx_reg >= C_LX && l_ovl) begin
                        bx_next     = C_LHIT;
                        dx_neg_next = 1'b0;
                    end else if (dx_neg_reg && bx_reg < C_BV) begin
                        // Right scores; next serve heads back toward the left.
                        score_r_next = sr_inc;
                        state_next   = (sr_inc == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
                        bx_next      = C_CX;
                        by_next      = C_CY;
                        dx_neg_next  = 1'b1;
                    end else if (!dx_neg_reg && bx_reg + C_BS + C_BV >= C_RX
                                 && bx_reg + C_BS <= C_RRIM && r_ovl) begin
                        bx_next     = C_RX - C_BS;
                        dx_neg_next = 1'b1;
                    end else if (!dx_neg_reg && bx_reg + C_BS + C_BV > C_HD) begin
                        score_l_next = sl_inc;
                        state_next   = (sl_inc == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
                        bx_next      = C_CX;
                        by_next      = C_CY;
                        dx_neg_next  = 1'b0;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    state_next   = S_SERVE;
                    score_l_next = 4'd0;
                    score_r_next = 4'd0;
                    cnt_next     = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign lpad_y     = lpad_reg;
    assign rpad_y     = rpad_reg;
    assign ball_x     = bx_reg[9:0];
    assign ball_y     = by_reg[9:0];
    assign score_l    = score_l_reg;
    assign score_r    = score_r_reg;
    assign game_state = state_reg;
    assign game_over  = over_reg;
    assign frame_tick = tick_reg;
endmodule
